// File: rtl/div_pkg.sv
// Shared types and constants for the RV32M divide sign sequencer.
// Holds op encodings, FSM states and the conditional-negate helper.
package div_pkg;

    localparam int DIV_XLEN  = 32;
    localparam int DIV_TAG_W = 5;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_ISSUE = ST_ISSUE,
        S_WAIT  = ST_WAIT,
        S_DONE  = ST_DONE,
        S_DRAIN = ST_DRAIN
    } state_t;

    localparam logic [DIV_XLEN-1:0] INT_MIN  = {1'b1, {DIV_XLEN-1{1'b0}}};
    localparam logic [DIV_XLEN-1:0] ALL_ONES = {DIV_XLEN{1'b1}};

    // Two's-complement negate when neg is set; INT_MIN maps to itself,
    // which is the correct unsigned magnitude.
    function automatic logic [DIV_XLEN-1:0] cond_neg(
        input logic [DIV_XLEN-1:0] x,
        input logic                neg
    );
        return neg ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/div_sign_ctrl_if.sv
// Issue/result handshake bundle between execute and the divide sequencer.
// master = issuing side, slave = the sequencer.
interface div_sign_ctrl_if
    import div_pkg::*;
#(
    parameter int XLEN  = DIV_XLEN,
    parameter int TAG_W = DIV_TAG_W
);
    logic             op_valid;
    logic             op_ready;
    logic [1:0]       op_sel;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic [TAG_W-1:0] tag_in;
    logic             flush;
    logic             result_valid;
    logic             result_ready;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] tag_out;

    modport master (
        output op_valid, op_sel, rs1, rs2, tag_in, flush, result_ready,
        input  op_ready, result_valid, result, tag_out
    );

    modport slave (
        input  op_valid, op_sel, rs1, rs2, tag_in, flush, result_ready,
        output op_ready, result_valid, result, tag_out
    );
endinterface

// File: rtl/div_sign_ctrl.sv
// RV32M divide sign sequencer: magnitudes out, sign-corrected result back.
// Divide-by-zero and signed overflow are resolved without the divider.
module div_sign_ctrl
    import div_pkg::*;
#(
    parameter int XLEN  = DIV_XLEN,
    parameter int TAG_W = DIV_TAG_W
) (
    input  logic            CLK,
    input  logic            rst_n,
    div_sign_ctrl_if.slave  ifc,
    output logic [XLEN-1:0] div_dividend,
    output logic [XLEN-1:0] div_divisor,
    output logic            div_valid,
    input  logic [XLEN-1:0] div_quotient,
    input  logic [XLEN-1:0] div_remainder,
    input  logic            div_ready
);

    state_t           state;
    logic             op_ready_q;
    logic             rvalid_q;
    logic [XLEN-1:0]  result_q;
    logic [TAG_W-1:0] tag_q;
    logic             rem_q;
    logic             neg_q_q;
    logic             neg_r_q;

    logic             signed_op;
    logic             rem_op;
    logic             s1;
    logic             s2;
    logic             div0;
    logic             ovf;
    logic             accept;
    logic [XLEN-1:0]  sel_val;
    logic             sel_neg;
    logic [XLEN-1:0]  corrected;

    assign ifc.op_ready     = op_ready_q;
    assign ifc.result_valid = rvalid_q;
    assign ifc.result       = result_q;
    assign ifc.tag_out      = tag_q;

    // Decode the incoming request and the divider return path.
    always_comb begin
        signed_op = ~ifc.op_sel[0];
        rem_op    = ifc.op_sel[1];
        s1        = signed_op & ifc.rs1[XLEN-1];
        s2        = signed_op & ifc.rs2[XLEN-1];
        div0      = (ifc.rs2 == '0);
        ovf       = signed_op & (ifc.rs1 == INT_MIN)
                  & (ifc.rs2 == ALL_ONES);
        accept    = ifc.op_valid & op_ready_q & ~ifc.flush;
        sel_val   = rem_q ? div_remainder : div_quotient;
        sel_neg   = rem_q ? neg_r_q : neg_q_q;
        corrected = cond_neg(sel_val, sel_neg);
    end

    // Sequencer FSM with registered handshake and divider outputs.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            op_ready_q   <= 1'b1;
            rvalid_q     <= 1'b0;
            result_q     <= '0;
            tag_q        <= '0;
            rem_q        <= 1'b0;
            neg_q_q      <= 1'b0;
            neg_r_q      <= 1'b0;
            div_valid    <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
        end else begin
            div_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        tag_q      <= ifc.tag_in;
                        rem_q      <= rem_op;
                        neg_q_q    <= s1 ^ s2;
                        neg_r_q    <= s1;
                        op_ready_q <= 1'b0;
                        if (div0) begin
                            result_q <= rem_op ? ifc.rs1 : ALL_ONES;
                            rvalid_q <= 1'b1;
                            state    <= S_DONE;
                        end else if (ovf) begin
                            result_q <= rem_op ? '0 : INT_MIN;
                            rvalid_q <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            div_dividend <= cond_neg(ifc.rs1, s1);
                            div_divisor  <= cond_neg(ifc.rs2, s2);
                            div_valid    <= 1'b1;
                            state        <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    state <= ifc.flush ? S_DRAIN : S_WAIT;
                end
                S_WAIT: begin
                    if (ifc.flush) begin
                        state <= S_DRAIN;
                    end else if (div_ready) begin
                        result_q <= corrected;
                        rvalid_q <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (ifc.flush || ifc.result_ready) begin
                        rvalid_q   <= 1'b0;
                        op_ready_q <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (div_ready) begin
                        op_ready_q <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    rvalid_q   <= 1'b0;
                    op_ready_q <= 1'b1;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_sign_ctrl.sv
// Directed bench for div_sign_ctrl; divider responses are driven by hand.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_div_sign_ctrl;
    import div_pkg::*;

    logic        CLK;
    logic        rst_n;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic        div_valid;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;
    logic        div_ready;

    int n_vec;
    int n_err;
    int n_pulse;
    int p0;

    div_sign_ctrl_if #(.XLEN(32), .TAG_W(5)) ifc ();

    div_sign_ctrl #(.XLEN(32), .TAG_W(5)) dut (
        .CLK           (CLK),
        .rst_n         (rst_n),
        .ifc           (ifc),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_valid     (div_valid),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .div_ready     (div_ready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Count divider start pulses seen on rising edges.
    always @(posedge CLK) begin
        if (div_valid) n_pulse <= n_pulse + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h required %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic issue(input logic [1:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] t);
        ifc.op_valid = 1'b1;
        ifc.op_sel   = sel;
        ifc.rs1      = a;
        ifc.rs2      = b;
        ifc.tag_in   = t;
        tick();
        ifc.op_valid = 1'b0;
    endtask

    task automatic respond(input logic [31:0] q, input logic [31:0] r);
        div_quotient  = q;
        div_remainder = r;
        div_ready     = 1'b1;
        tick();
        div_ready     = 1'b0;
    endtask

    task automatic ack();
        ifc.result_ready = 1'b1;
        tick();
        ifc.result_ready = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        n_pulse = 0;
        rst_n = 1'b0;
        ifc.op_valid = 1'b0;
        ifc.op_sel = 2'b00;
        ifc.rs1 = '0;
        ifc.rs2 = '0;
        ifc.tag_in = '0;
        ifc.flush = 1'b0;
        ifc.result_ready = 1'b0;
        div_quotient = '0;
        div_remainder = '0;
        div_ready = 1'b0;
        repeat (2) tick();

        chk("rst_op_ready", {31'b0, ifc.op_ready}, 32'd1);
        chk("rst_rvalid", {31'b0, ifc.result_valid}, 32'd0);
        chk("rst_div_valid", {31'b0, div_valid}, 32'd0);
        chk("rst_result", ifc.result, 32'd0);
        rst_n = 1'b1;
        tick();

        // DIV -7 / 2 -> -3
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd3);
        chk("div_issue_valid", {31'b0, div_valid}, 32'd1);
        chk("div_dividend", div_dividend, 32'd7);
        chk("div_divisor", div_divisor, 32'd2);
        chk("div_op_ready", {31'b0, ifc.op_ready}, 32'd0);
        tick();
        chk("div_pulse_end", {31'b0, div_valid}, 32'd0);
        chk("div_dividend_hold", div_dividend, 32'd7);
        respond(32'd3, 32'd1);
        chk("div_rvalid", {31'b0, ifc.result_valid}, 32'd1);
        chk("div_result", ifc.result, 32'hFFFF_FFFD);
        chk("div_tag", {27'b0, ifc.tag_out}, 32'd3);
        ack();
        chk("div_ack_rvalid", {31'b0, ifc.result_valid}, 32'd0);
        chk("div_ack_ready", {31'b0, ifc.op_ready}, 32'd1);

        // REM -7 % 2 -> -1
        issue(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd4);
        chk("rem_dividend", div_dividend, 32'd7);
        tick();
        respond(32'd3, 32'd1);
        chk("rem_result", ifc.result, 32'hFFFF_FFFF);
        ack();

        // REMU: operands pass through unchanged
        issue(OP_REMU, 32'hFFFF_FFF9, 32'd2, 5'd5);
        chk("remu_dividend", div_dividend, 32'hFFFF_FFF9);
        chk("remu_divisor", div_divisor, 32'd2);
        tick();
        respond(32'h7FFF_FFFC, 32'd1);
        chk("remu_result", ifc.result, 32'd1);
        ack();

        // DIVU by zero: no issue, result one cycle after accept
        p0 = n_pulse;
        issue(OP_DIVU, 32'd5, 32'd0, 5'd6);
        chk("divu0_rvalid", {31'b0, ifc.result_valid}, 32'd1);
        chk("divu0_result", ifc.result, 32'hFFFF_FFFF);
        chk("divu0_tag", {27'b0, ifc.tag_out}, 32'd6);
        chk("divu0_nopulse", n_pulse, p0);
        ack();

        // REM by zero returns dividend
        issue(OP_REM, 32'h0000_1234, 32'd0, 5'd7);
        chk("rem0_rvalid", {31'b0, ifc.result_valid}, 32'd1);
        chk("rem0_result", ifc.result, 32'h0000_1234);
        ack();

        // Signed overflow
        issue(OP_DIV, INT_MIN, ALL_ONES, 5'd8);
        chk("ovf_div_rvalid", {31'b0, ifc.result_valid}, 32'd1);
        chk("ovf_div_result", ifc.result, 32'h8000_0000);
        ack();
        issue(OP_REM, INT_MIN, ALL_ONES, 5'd9);
        chk("ovf_rem_result", ifc.result, 32'd0);
        chk("ovf_nopulse", n_pulse, p0);
        ack();

        // flush with op_valid in IDLE: nothing accepted
        ifc.op_valid = 1'b1;
        ifc.op_sel = OP_DIV;
        ifc.rs1 = 32'd9;
        ifc.rs2 = 32'd3;
        ifc.flush = 1'b1;
        tick();
        ifc.op_valid = 1'b0;
        ifc.flush = 1'b0;
        chk("idle_flush_ready", {31'b0, ifc.op_ready}, 32'd1);
        chk("idle_flush_nopulse", n_pulse, p0);
        chk("idle_flush_rvalid", {31'b0, ifc.result_valid}, 32'd0);

        // flush in WAIT -> DRAIN, divider result discarded
        issue(OP_DIV, 32'd100, 32'd7, 5'd10);
        tick();
        ifc.flush = 1'b1;
        tick();
        ifc.flush = 1'b0;
        chk("drain_ready", {31'b0, ifc.op_ready}, 32'd0);
        tick();
        chk("drain_ready2", {31'b0, ifc.op_ready}, 32'd0);
        respond(32'd99, 32'd5);
        chk("drain_rvalid", {31'b0, ifc.result_valid}, 32'd0);
        chk("drain_back_ready", {31'b0, ifc.op_ready}, 32'd1);

        issue(OP_DIV, 32'd100, 32'd7, 5'd11);
        chk("post_drain_dividend", div_dividend, 32'd100);
        chk("post_drain_divisor", div_divisor, 32'd7);
        tick();
        respond(32'd14, 32'd2);
        chk("post_drain_result", ifc.result, 32'd14);
        chk("post_drain_tag", {27'b0, ifc.tag_out}, 32'd11);
        ack();

        // Hold in DONE for 5 cycles with op_valid asserted
        issue(OP_DIV, 32'd20, 32'hFFFF_FFFD, 5'd17);
        chk("hold_divisor", div_divisor, 32'd3);
        tick();
        respond(32'd6, 32'd2);
        p0 = n_pulse;
        ifc.op_valid = 1'b1;
        ifc.rs1 = 32'd1;
        ifc.rs2 = 32'd1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_result", ifc.result, 32'hFFFF_FFFA);
            chk("hold_tag", {27'b0, ifc.tag_out}, 32'd17);
            chk("hold_ready", {31'b0, ifc.op_ready}, 32'd0);
            chk("hold_rvalid", {31'b0, ifc.result_valid}, 32'd1);
        end
        ifc.op_valid = 1'b0;
        chk("hold_nopulse", n_pulse, p0);
        ack();

        // flush in DONE drops the result
        issue(OP_DIVU, 32'd8, 32'd0, 5'd1);
        ifc.flush = 1'b1;
        tick();
        ifc.flush = 1'b0;
        chk("done_flush_rvalid", {31'b0, ifc.result_valid}, 32'd0);
        chk("done_flush_ready", {31'b0, ifc.op_ready}, 32'd1);

        // Asynchronous reset in WAIT
        issue(OP_DIV, 32'd100, 32'd7, 5'd2);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_op_ready", {31'b0, ifc.op_ready}, 32'd1);
        chk("arst_rvalid", {31'b0, ifc.result_valid}, 32'd0);
        chk("arst_dividend", div_dividend, 32'd0);
        chk("arst_divisor", div_divisor, 32'd0);
        chk("arst_result", ifc.result, 32'd0);
        chk("arst_tag", {27'b0, ifc.tag_out}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_after_ready", {31'b0, ifc.op_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
